// File: rtl/mcpu_state_sequencer_pkg.sv
// mcpu_defs: the definitions shared by the multi-cycle MIPS control path.
// The sequencer and the downstream decode LUT both import this package,
// so phase codes and opcode/funct values stay consistent between them.
//   state_t   : phase encodings IF/ID/EXEC/MEM/WB/TRAP
//   OP_* / FN_*: opcode and R-type funct constants
//   path_t    : per-instruction path descriptor produced by mcpu_path_end
package mcpu_defs;

   typedef enum logic [2:0] {
      ST_IF   = 3'd0,
      ST_ID   = 3'd1,
      ST_EXEC = 3'd2,
      ST_MEM  = 3'd3,
      ST_WB   = 3'd4,
      ST_TRAP = 3'd7
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   // last  : phase on which the instruction retires
   // mem   : path passes through MEM between EXEC and WB
   // legal : opcode/funct pair is implemented
   typedef struct packed {
      state_t last;
      logic   mem;
      logic   legal;
   } path_t;

endpackage

// File: rtl/mcpu_state_sequencer_if.sv
// Handshake bundle between the instruction/memory side and the sequencer.
//   run, opcode, funct, mem_ready      : driven by the master (upstream)
//   state, ir_load, retire, illegal,
//   cycle_count, instret_count         : driven by the sequencer (slave)
interface mcpu_state_sequencer_if #(
   parameter int CNT_W = 32
);
   logic             run;
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic             mem_ready;
   logic [2:0]       state;
   logic             ir_load;
   logic             retire;
   logic             illegal;
   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] instret_count;

   modport master (
      output run, opcode, funct, mem_ready,
      input  state, ir_load, retire, illegal, cycle_count, instret_count
   );

   modport slave (
      input  run, opcode, funct, mem_ready,
      output state, ir_load, retire, illegal, cycle_count, instret_count
   );
endinterface

// File: rtl/mcpu_state_sequencer_path_end.sv
// mcpu_path_end: combinational map from (opcode, funct) to the phase on
// which the instruction retires, whether it visits MEM, and a legal flag.
//   opcode, funct : instruction fields (meaningful from ID onward)
//   path          : path_t descriptor
module mcpu_path_end
   import mcpu_defs::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output path_t      path
);

   always_comb begin
      path = '{last: ST_WB, mem: 1'b0, legal: 1'b1};
      case (opcode)
         OP_LW, OP_BEQ, OP_BNE: path.mem = 1'b1;
         OP_SW, OP_JAL: begin
            path.last = ST_MEM;
            path.mem  = 1'b1;
         end
         OP_J:             path.last = ST_ID;
         OP_ADDI, OP_XORI: path.last = ST_WB;
         OP_RTYPE: begin
            case (funct)
               FN_ADD, FN_SUB, FN_SLT: path.last  = ST_WB;
               FN_JR:                  path.last  = ST_EXEC;
               default:                path.legal = 1'b0;
            endcase
         end
         default: path.legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/mcpu_state_sequencer.sv
// mcpu_state_sequencer: multi-cycle MIPS phase sequencer.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : run/opcode/funct/mem_ready in; state, ir_load, retire,
//                  illegal, cycle_count, instret_count out
// Optional build macro MCPU_PERF_CNTR_EN adds the cycle / retired
// instruction counters; without it both count outputs are tied to zero.
module mcpu_state_sequencer
   import mcpu_defs::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   reset_n,
   mcpu_state_sequencer_if.slave  bus
);

   state_t state;
   logic   illegal;
   path_t  path;
   logic   advance;
   logic   at_end;
   logic   retire;

   mcpu_path_end u_path_end (
      .opcode (bus.opcode),
      .funct  (bus.funct),
      .path   (path)
   );

   // IF and MEM wait on memory; everything else is single-cycle.
   assign advance = bus.run &&
                    (((state == ST_IF) || (state == ST_MEM)) ? bus.mem_ready : 1'b1);

   // last is never IF or TRAP, so opcode is never consulted while fetching
   // and TRAP can never retire.
   assign at_end  = path.legal && (state == path.last);
   assign retire  = reset_n && advance && at_end;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IF;
         illegal <= 1'b0;
      end else if (state != ST_TRAP && advance) begin
         case (state)
            ST_IF: state <= ST_ID;
            ST_ID: begin
               if (!path.legal) begin
                  state   <= ST_TRAP;
                  illegal <= 1'b1;
               end else if (at_end) state <= ST_IF;
               else                 state <= ST_EXEC;
            end
            ST_EXEC: begin
               if (at_end)        state <= ST_IF;
               else if (path.mem) state <= ST_MEM;
               else               state <= ST_WB;
            end
            ST_MEM:  state <= at_end ? ST_IF : ST_WB;
            ST_WB:   state <= ST_IF;
            default: state <= ST_IF;   // encodings 5/6: recovery only
         endcase
      end
   end

   assign bus.state   = state;
   assign bus.illegal = illegal;
   assign bus.retire  = retire;
   assign bus.ir_load = reset_n && bus.run && bus.mem_ready && (state == ST_IF);

`ifdef MCPU_PERF_CNTR_EN
   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] instret_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cycle_count   <= '0;
         instret_count <= '0;
      end else if (state != ST_TRAP) begin
         cycle_count <= cycle_count + CNT_W'(1);
         if (retire) instret_count <= instret_count + CNT_W'(1);
      end
   end

   assign bus.cycle_count   = cycle_count;
   assign bus.instret_count = instret_count;
`else
   assign bus.cycle_count   = {CNT_W{1'b0}};
   assign bus.instret_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mcpu_state_sequencer.sv
// Bench for mcpu_state_sequencer. Each stimulus row is
// {run, mem_ready, expected state[2:0], expected retire, expected ir_load};
// the expectation is queued when the row is driven and popped when the
// DUT outputs are sampled 1 ns later.
module tb_mcpu_state_sequencer;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;

   mcpu_state_sequencer_if #(.CNT_W(32)) bus ();

   mcpu_state_sequencer #(.CNT_W(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] st;
      logic       ret;
      logic       irl;
   } exp_t;

   exp_t   sbq[$];
   int     n_chk  = 0;
   int     n_fail = 0;
   longint exp_cyc = 0;
   longint exp_ins = 0;

   function automatic logic [31:0] cyc_req();
`ifdef MCPU_PERF_CNTR_EN
      return 32'(exp_cyc);
`else
      return 32'd0;
`endif
   endfunction

   function automatic logic [31:0] ins_req();
`ifdef MCPU_PERF_CNTR_EN
      return 32'(exp_ins);
`else
      return 32'd0;
`endif
   endfunction

   task automatic drive_row(input logic [6:0] r);
      exp_t e;
      bus.run       = r[6];
      bus.mem_ready = r[5];
      e.st  = r[4:2];
      e.ret = r[1];
      e.irl = r[0];
      sbq.push_back(e);
      if (r[1]) exp_ins++;
   endtask

   // Advance to 1 ns after the next rising edge; count that edge as a
   // counted cycle when the state before it was not TRAP.
   task automatic tick(input bit cnt);
      @(posedge clk);
      #1;
      if (cnt) exp_cyc++;
   endtask

   task automatic test_reset();
      bus.run = 1'b1; bus.mem_ready = 1'b1; bus.opcode = 6'd0; bus.funct = 6'd0;
      #2 reset_n = 1'b0;
      #3;
      n_chk++;
      if (bus.state !== 3'd0 || bus.illegal !== 1'b0 || bus.retire !== 1'b0 ||
          bus.ir_load !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: state=%0d illegal=%b retire=%b ir_load=%b, required 0 0 0 0",
                  bus.state, bus.illegal, bus.retire, bus.ir_load);
      end
      n_chk++;
      if (bus.cycle_count !== 32'd0 || bus.instret_count !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_counters: cycle=%0d instret=%0d, required 0 0",
                  bus.cycle_count, bus.instret_count);
      end
      @(posedge clk);
      #1 reset_n = 1'b1;
      exp_cyc = 0; exp_ins = 0;
   endtask

   task automatic test_paths();
      logic [5:0]  op [12];
      logic [5:0]  fn [12];
      int          len[12];
      logic [14:0] sts[12];
      exp_t        e;
      op[0]  = 6'b100011; fn[0]  = 6'b000000; len[0]  = 5; sts[0]  = 15'b100_011_010_001_000; // LW
      op[1]  = 6'b101011; fn[1]  = 6'b000000; len[1]  = 4; sts[1]  = 15'b000_011_010_001_000; // SW
      op[2]  = 6'b000010; fn[2]  = 6'b000000; len[2]  = 2; sts[2]  = 15'b000_000_000_001_000; // J
      op[3]  = 6'b000011; fn[3]  = 6'b000000; len[3]  = 4; sts[3]  = 15'b000_011_010_001_000; // JAL
      op[4]  = 6'b000100; fn[4]  = 6'b000000; len[4]  = 5; sts[4]  = 15'b100_011_010_001_000; // BEQ
      op[5]  = 6'b000101; fn[5]  = 6'b000000; len[5]  = 5; sts[5]  = 15'b100_011_010_001_000; // BNE
      op[6]  = 6'b001000; fn[6]  = 6'b000000; len[6]  = 4; sts[6]  = 15'b000_100_010_001_000; // ADDI
      op[7]  = 6'b001110; fn[7]  = 6'b000000; len[7]  = 4; sts[7]  = 15'b000_100_010_001_000; // XORI
      op[8]  = 6'b000000; fn[8]  = 6'b100000; len[8]  = 4; sts[8]  = 15'b000_100_010_001_000; // ADD
      op[9]  = 6'b000000; fn[9]  = 6'b100010; len[9]  = 4; sts[9]  = 15'b000_100_010_001_000; // SUB
      op[10] = 6'b000000; fn[10] = 6'b101010; len[10] = 4; sts[10] = 15'b000_100_010_001_000; // SLT
      op[11] = 6'b000000; fn[11] = 6'b001000; len[11] = 3; sts[11] = 15'b000_000_010_001_000; // JR
      for (int i = 0; i < 12; i++) begin
         bus.opcode = op[i];
         bus.funct  = fn[i];
         for (int c = 0; c < len[i]; c++) begin
            drive_row({2'b11, sts[i][3*c +: 3], (c == len[i]-1), (c == 0)});
            e = sbq.pop_front();
            #1;
            n_chk++;
            if (bus.state !== e.st || bus.retire !== e.ret || bus.ir_load !== e.irl) begin
               n_fail++;
               $display("FAIL path_%0d_cyc%0d: state=%0d retire=%b ir_load=%b, required state=%0d retire=%b ir_load=%b",
                        i, c, bus.state, bus.retire, bus.ir_load, e.st, e.ret, e.irl);
            end
            tick(1'b1);
         end
      end
      n_chk++;
      if (bus.state !== 3'd0 || bus.cycle_count !== cyc_req() || bus.instret_count !== ins_req()) begin
         n_fail++;
         $display("FAIL paths_end: state=%0d cycle=%0d instret=%0d, required 0 %0d %0d",
                  bus.state, bus.cycle_count, bus.instret_count, cyc_req(), ins_req());
      end
   endtask

   task automatic test_mem_wait();
      logic [6:0] tab[10];
      exp_t e;
      tab = '{7'b10_000_00,  // IF, memory not ready
              7'b01_000_00,  // IF, run low: mem_ready ignored, no ir_load
              7'b11_000_01,  // IF fetch
              7'b11_001_00,  // ID
              7'b11_010_00,  // EXEC
              7'b10_011_00,  // MEM wait x3
              7'b10_011_00,
              7'b10_011_00,
              7'b11_011_10,  // MEM done, SW retires
              7'b00_000_00}; // back in IF
      bus.opcode = 6'b101011; bus.funct = 6'd0;
      for (int i = 0; i < 10; i++) begin
         drive_row(tab[i]);
         e = sbq.pop_front();
         #1;
         n_chk++;
         if (bus.state !== e.st || bus.retire !== e.ret || bus.ir_load !== e.irl) begin
            n_fail++;
            $display("FAIL mem_wait_row%0d: state=%0d retire=%b ir_load=%b, required state=%0d retire=%b ir_load=%b",
                     i, bus.state, bus.retire, bus.ir_load, e.st, e.ret, e.irl);
         end
         tick(1'b1);
      end
   endtask

   task automatic test_run_stall();
      logic [6:0] tab[7];
      exp_t e;
      tab = '{7'b11_000_01, 7'b11_001_00,
              7'b01_010_00, 7'b01_010_00, 7'b11_010_00,  // EXEC held by run=0
              7'b11_100_10, 7'b00_000_00};
      bus.opcode = 6'b000000; bus.funct = 6'b100000;
      for (int i = 0; i < 7; i++) begin
         drive_row(tab[i]);
         e = sbq.pop_front();
         #1;
         n_chk++;
         if (bus.state !== e.st || bus.retire !== e.ret || bus.ir_load !== e.irl) begin
            n_fail++;
            $display("FAIL run_stall_row%0d: state=%0d retire=%b ir_load=%b, required state=%0d retire=%b ir_load=%b",
                     i, bus.state, bus.retire, bus.ir_load, e.st, e.ret, e.irl);
         end
         tick(1'b1);
      end
      n_chk++;
      if (bus.cycle_count !== cyc_req() || bus.instret_count !== ins_req()) begin
         n_fail++;
         $display("FAIL run_stall_counters: cycle=%0d instret=%0d, required %0d %0d",
                  bus.cycle_count, bus.instret_count, cyc_req(), ins_req());
      end
   endtask

   task automatic test_illegal(input logic [5:0] op, input logic [5:0] fn);
      logic [6:0] tab[6];
      exp_t e;
      tab = '{7'b11_000_01, 7'b11_001_00,
              7'b00_111_00, 7'b11_111_00, 7'b10_111_00, 7'b01_111_00};
      bus.opcode = op; bus.funct = fn;
      for (int i = 0; i < 6; i++) begin
         drive_row(tab[i]);
         e = sbq.pop_front();
         #1;
         n_chk++;
         if (bus.state !== e.st || bus.retire !== e.ret || bus.ir_load !== e.irl) begin
            n_fail++;
            $display("FAIL illegal_%b_%b_row%0d: state=%0d retire=%b ir_load=%b, required state=%0d retire=%b ir_load=%b",
                     op, fn, i, bus.state, bus.retire, bus.ir_load, e.st, e.ret, e.irl);
         end
         tick(e.st != 3'd7);
      end
      n_chk++;
      if (bus.illegal !== 1'b1 || bus.cycle_count !== cyc_req() || bus.instret_count !== ins_req()) begin
         n_fail++;
         $display("FAIL trap_sticky: illegal=%b cycle=%0d instret=%0d, required 1 %0d %0d",
                  bus.illegal, bus.cycle_count, bus.instret_count, cyc_req(), ins_req());
      end
      reset_n = 1'b0;
      #1;
      n_chk++;
      if (bus.state !== 3'd0 || bus.illegal !== 1'b0) begin
         n_fail++;
         $display("FAIL trap_reset: state=%0d illegal=%b, required 0 0", bus.state, bus.illegal);
      end
      tick(1'b0);
      reset_n = 1'b1;
      exp_cyc = 0; exp_ins = 0;
   endtask

   task automatic test_perf_j();
      logic [6:0] tab[2];
      exp_t e;
      tab = '{7'b11_000_01, 7'b11_001_10};
      bus.opcode = 6'b000010; bus.funct = 6'd0;
      for (int i = 0; i < 2; i++) begin
         drive_row(tab[i]);
         e = sbq.pop_front();
         #1;
         n_chk++;
         if (bus.state !== e.st || bus.retire !== e.ret || bus.ir_load !== e.irl) begin
            n_fail++;
            $display("FAIL perf_j_row%0d: state=%0d retire=%b ir_load=%b, required state=%0d retire=%b ir_load=%b",
                     i, bus.state, bus.retire, bus.ir_load, e.st, e.ret, e.irl);
         end
         tick(1'b1);
      end
      n_chk++;
      if (bus.state !== 3'd0 || bus.cycle_count !== cyc_req() || bus.instret_count !== ins_req()) begin
         n_fail++;
         $display("FAIL perf_j_counts: state=%0d cycle=%0d instret=%0d, required 0 %0d %0d",
                  bus.state, bus.cycle_count, bus.instret_count, cyc_req(), ins_req());
      end
   endtask

   task automatic test_async_reset();
      logic [6:0] tab[3];
      exp_t e;
      tab = '{7'b11_000_01, 7'b11_001_00, 7'b11_010_00};
      bus.opcode = 6'b000100; bus.funct = 6'd0;
      for (int i = 0; i < 3; i++) begin
         drive_row(tab[i]);
         e = sbq.pop_front();
         #1;
         n_chk++;
         if (bus.state !== e.st || bus.retire !== e.ret || bus.ir_load !== e.irl) begin
            n_fail++;
            $display("FAIL async_beq_row%0d: state=%0d retire=%b ir_load=%b, required state=%0d retire=%b ir_load=%b",
                     i, bus.state, bus.retire, bus.ir_load, e.st, e.ret, e.irl);
         end
         if (i < 2) tick(1'b1);
      end
      // Mid-EXEC, well away from any clock edge.
      #2 reset_n = 1'b0;
      #1;
      n_chk++;
      if (bus.state !== 3'd0 || bus.retire !== 1'b0 || bus.ir_load !== 1'b0 ||
          bus.cycle_count !== 32'd0 || bus.instret_count !== 32'd0) begin
         n_fail++;
         $display("FAIL async_reset: state=%0d retire=%b ir_load=%b cycle=%0d instret=%0d, required all 0",
                  bus.state, bus.retire, bus.ir_load, bus.cycle_count, bus.instret_count);
      end
      tick(1'b0);
      reset_n = 1'b1;
      exp_cyc = 0; exp_ins = 0;
   endtask

   initial begin
      test_reset();
      test_paths();
      test_mem_wait();
      test_run_stall();
      test_illegal(6'b000000, 6'b000001);
      test_illegal(6'b111111, 6'b100000);
      test_perf_j();
      test_async_reset();
      test_perf_j();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
